level_debouncer: RTL and testbench

- Conditions a raw, asynchronous, bouncy input (button, switch, external strobe) into a clean, glitch-free, clock-synchronous level.
- Sits directly upstream of the one-shot stage (level_to_pulse); its `level` output drives that block's level input.
- Structure: a multi-flop synchronizer, then a four-state stability FSM with a saturating-compare counter.

---
 rtl/level_debouncer.sv | 122 ++++++++++++
 tb/tb_level_debouncer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/level_debouncer.sv
// level_debouncer: synchronizes a raw, bouncy input and qualifies each
// transition over STABLE_CYCLES+1 consecutive matching samples before
// letting the registered level output follow it.
module level_debouncer #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 1000,
  parameter int unsigned CNT_W         = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic level,
  output logic settling
);

  localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_LOW  = 2'd0,
    ST_RISE = 2'd1,
    ST_HIGH = 2'd2,
    ST_FALL = 2'd3
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             settling_q, settling_d;

  // Synchronizer chain; stage 0 samples the asynchronous input.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_LOW;
      cnt_q      <= '0;
      level_q    <= 1'b0;
      settling_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      level_q    <= level_d;
      settling_q <= settling_d;
    end
  end

  // Next-state and counter: a candidate must match for STABLE_CYCLES more samples.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_LOW: begin
        if (sync_s) begin
          state_d = ST_RISE;
          cnt_d   = CNT_ONE;
        end
      end
      ST_RISE: begin
        if (!sync_s) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_CNT) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (!sync_s) begin
          state_d = ST_FALL;
          cnt_d   = CNT_ONE;
        end
      end
      ST_FALL: begin
        if (sync_s) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_CNT) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs track the state register.
  always_comb begin
    level_d    = 1'b0;
    settling_d = 1'b0;
    unique case (state_d)
      ST_LOW:  begin level_d = 1'b0; settling_d = 1'b0; end
      ST_RISE: begin level_d = 1'b0; settling_d = 1'b1; end
      ST_HIGH: begin level_d = 1'b1; settling_d = 1'b0; end
      ST_FALL: begin level_d = 1'b1; settling_d = 1'b1; end
      default: begin level_d = 1'b0; settling_d = 1'b0; end
    endcase
  end

  assign level    = level_q;
  assign settling = settling_q;

endmodule

// File: tb/tb_level_debouncer.sv
// Bench for level_debouncer: directed scenarios plus random bouncy input,
// checked against a sample-window reference model.
module tb_level_debouncer;

  localparam int unsigned SYNC_STAGES   = 2;
  localparam int unsigned STABLE_CYCLES = 4;
  localparam int unsigned CNT_W         = 16;

  logic clk = 1'b0;
  logic reset;
  logic raw_in;
  logic level;
  logic settling;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: chain of raw values in flight, and the synchronized
  // samples seen since level last changed.
  bit chain[$];
  bit win[$];
  bit m_level;
  bit m_settling;
  int m_rises;
  int dut_rises;
  bit dut_prev_level;

  level_debouncer #(
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .raw_in  (raw_in),
    .level   (level),
    .settling(settling)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Level flips once the last STABLE_CYCLES+1 samples all disagree with it.
  task automatic model_edge(input bit r, input bit rs);
    bit s;
    bit all_diff;
    if (rs) begin
      chain.delete();
      for (int i = 0; i < int'(SYNC_STAGES); i++) chain.push_back(1'b0);
      win.delete();
      m_level = 1'b0;
    end else begin
      s = chain[chain.size()-1];
      void'(chain.pop_back());
      chain.push_front(r);
      win.push_back(s);
      if (win.size() > int'(STABLE_CYCLES) + 1) void'(win.pop_front());
      all_diff = (win.size() == int'(STABLE_CYCLES) + 1);
      foreach (win[i]) if (win[i] == m_level) all_diff = 1'b0;
      if (all_diff) begin
        m_level = ~m_level;
        if (m_level) m_rises++;
        win.delete();
      end
    end
    m_settling = (win.size() > 0) && (win[win.size()-1] != m_level);
  endtask

  // One clock: drive at negedge, model on posedge, compare on next negedge.
  task automatic step(input bit r, input bit rs);
    raw_in = r;
    reset  = rs;
    @(posedge clk);
    model_edge(r, rs);
    @(negedge clk);
    check_eq("level", 32'(level), 32'(m_level));
    check_eq("settling", 32'(settling), 32'(m_settling));
    if (level && !dut_prev_level) dut_rises++;
    dut_prev_level = level;
  endtask

  initial begin
    bit seen_settle;
    int runlen;
    bit rv;
    m_rises = 0;
    dut_rises = 0;
    dut_prev_level = 1'b0;
    raw_in = 1'b0;
    reset  = 1'b1;
    @(negedge clk);

    // Reset state
    step(1'b0, 1'b1);
    check_eq("reset_level", 32'(level), 32'd0);
    check_eq("reset_settling", 32'(settling), 32'd0);

    // Clean rise: raw goes high before E10
    for (int e = 1; e <= 20; e++) begin
      step(e >= 10, 1'b0);
      if (e == 11) check_eq("rise_e11_settling", 32'(settling), 32'd0);
      if (e == 12) check_eq("rise_e12_settling", 32'(settling), 32'd1);
      if (e == 15) check_eq("rise_e15_level", 32'(level), 32'd0);
      if (e == 16) begin
        check_eq("rise_e16_level", 32'(level), 32'd1);
        check_eq("rise_e16_settling", 32'(settling), 32'd0);
      end
    end

    // Short low glitch while high is rejected
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
    check_eq("glitch_high_level", 32'(level), 32'd1);

    // Sustained low: level falls at capture+6
    for (int k = 0; k <= 10; k++) begin
      step(1'b0, 1'b0);
      if (k == 5) check_eq("fall_c5_level", 32'(level), 32'd1);
      if (k == 6) check_eq("fall_c6_level", 32'(level), 32'd0);
    end

    // Bounce reject from low: three high samples only
    seen_settle = 1'b0;
    for (int i = 0; i < 13; i++) begin
      step(i < 3, 1'b0);
      if (settling) seen_settle = 1'b1;
      if (level) check_eq("bounce_level_low", 32'(level), 32'd0);
    end
    check_eq("bounce_settle_seen", 32'(seen_settle), 32'd1);
    check_eq("bounce_settle_end", 32'(settling), 32'd0);
    check_eq("bounce_level_end", 32'(level), 32'd0);

    // Bouncy rise: 1,0,1,0 then held 1
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    for (int k = 0; k <= 8; k++) begin
      step(1'b1, 1'b0);
      if (k == 5) check_eq("bouncy_c5_level", 32'(level), 32'd0);
      if (k == 6) check_eq("bouncy_c6_level", 32'(level), 32'd1);
    end

    // Return low, then reset in the middle of a rise qualification
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    check_eq("midq_settling_before", 32'(settling), 32'd1);
    step(1'b1, 1'b1);
    check_eq("midq_reset_level", 32'(level), 32'd0);
    check_eq("midq_reset_settling", 32'(settling), 32'd0);
    for (int n = 0; n <= 8; n++) begin
      step(1'b1, 1'b0);
      if (n == 5) check_eq("midq_n5_level", 32'(level), 32'd0);
      if (n == 6) check_eq("midq_n6_level", 32'(level), 32'd1);
    end

    // Random bouncy input with occasional resets
    for (int b = 0; b < 400; b++) begin
      rv = 1'($urandom_range(0, 1));
      runlen = int'($urandom_range(1, 8));
      for (int i = 0; i < runlen; i++) step(rv, $urandom_range(0, 63) == 0);
    end

    // One downstream pulse per debounced rise
    check_eq("rise_count", 32'(dut_rises), 32'(m_rises));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
